// File: rtl/cattrap_pkg.sv
// Constants and the move-FSM state type shared by the switch-to-move input path.
package cattrap_pkg;

   localparam int GRID_N = 8;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ISSUE       = 2'd1,
      WAIT_CHANGE = 2'd2
   } move_state_e;

endpackage

// File: rtl/switch_stabilizer.sv
// Two-flop synchronizer plus stability filter: the filtered vector only follows
// the inputs once they have held still for STABLE_CYCLES consecutive samples.
module switch_stabilizer #(
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20,
   parameter int WIDTH         = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_filt,
   output logic             stable
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] filt_q, filt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // The counter parks at CNT_MAX, so once qualified the vector keeps reloading
   // the same value and stable stays high until the next change.
   always_comb begin
      sync1_d  = sw_in;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      cnt_d    = cnt_q;
      filt_d   = filt_q;
      stable_d = stable_q;
      if (sync2_q != prev_q) begin
         cnt_d    = '0;
         stable_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         filt_d   = sync2_q;
         stable_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         filt_q   <= '0;
         stable_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         filt_q   <= filt_d;
         stable_q <= stable_d;
      end
   end

   assign sw_filt = filt_q;
   assign stable  = stable_q;

endmodule

// File: rtl/move_select_decoder.sv
// Turns the one-hot Row/Col switch banks into validated cell coordinates and
// hands one move per accepted submit to the game core over valid/ready.
module move_select_decoder
   import cattrap_pkg::*;
#(
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic [GRID_N-1:0]    row_sw,
   input  logic [GRID_N-1:0]    col_sw,
   input  logic                 submit,
   input  logic                 move_ready,
   output logic                 move_valid,
   output logic [IDX_W-1:0]     move_row,
   output logic [IDX_W-1:0]     move_col,
   output logic                 sel_stable,
   output logic                 sel_onehot,
   output logic [IDX_W-1:0]     sel_row,
   output logic [IDX_W-1:0]     sel_col,
   output logic                 sel_error
);

   localparam int SW_W = 2 * GRID_N;

   function automatic logic bank_onehot(input logic [GRID_N-1:0] v);
      int ones;
      ones = 0;
      for (int i = 0; i < GRID_N; i++) ones += int'(v[i]);
      return ones == 1;
   endfunction

   function automatic logic [IDX_W-1:0] bank_index(input logic [GRID_N-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < GRID_N; i++) if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   logic [SW_W-1:0]  filt;
   logic             filt_stable;
   logic [GRID_N-1:0] row_bank, col_bank;
   logic             row_ok, col_ok, accept;

   logic             sel_stable_q, sel_stable_d;
   logic             sel_onehot_q, sel_onehot_d;
   logic [IDX_W-1:0] sel_row_q, sel_row_d;
   logic [IDX_W-1:0] sel_col_q, sel_col_d;
   logic             sel_error_q, sel_error_d;
   logic             move_valid_q, move_valid_d;
   logic [IDX_W-1:0] move_row_q, move_row_d;
   logic [IDX_W-1:0] move_col_q, move_col_d;
   logic [SW_W-1:0]  snap_q, snap_d;
   move_state_e      state_q, state_d;

   switch_stabilizer #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .WIDTH         (SW_W)
   ) u_stabilizer (
      .clk     (clk),
      .Reset   (Reset),
      .sw_in   ({row_sw, col_sw}),
      .sw_filt (filt),
      .stable  (filt_stable)
   );

   // sel_stable is re-registered alongside the decode so a submit never sees
   // "stable" paired with the coordinates of the previous filtered vector.
   always_comb begin
      row_bank     = filt[SW_W-1 -: GRID_N];
      col_bank     = filt[GRID_N-1:0];
      row_ok       = bank_onehot(row_bank);
      col_ok       = bank_onehot(col_bank);
      sel_stable_d = filt_stable;
      sel_onehot_d = row_ok && col_ok;
      sel_row_d    = row_ok ? bank_index(row_bank) : '0;
      sel_col_d    = col_ok ? bank_index(col_bank) : '0;
   end

   assign accept = submit && sel_stable_q && sel_onehot_q;

   always_comb begin
      state_d      = state_q;
      move_valid_d = move_valid_q;
      move_row_d   = move_row_q;
      move_col_d   = move_col_q;
      sel_error_d  = sel_error_q;
      snap_d       = snap_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               move_row_d   = sel_row_q;
               move_col_d   = sel_col_q;
               move_valid_d = 1'b1;
               sel_error_d  = 1'b0;
               state_d      = ISSUE;
            end else if (submit) begin
               sel_error_d = 1'b1;
            end
         end
         ISSUE: begin
            if (move_valid_q && move_ready) begin
               move_valid_d = 1'b0;
               snap_d       = filt;
               state_d      = WAIT_CHANGE;
            end
         end
         WAIT_CHANGE: begin
            // Re-arm only after the selection moves, so one cell cannot be sent twice.
            if (filt != snap_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         sel_stable_q <= 1'b0;
         sel_onehot_q <= 1'b0;
         sel_row_q    <= '0;
         sel_col_q    <= '0;
         sel_error_q  <= 1'b0;
         move_valid_q <= 1'b0;
         move_row_q   <= '0;
         move_col_q   <= '0;
         snap_q       <= '0;
      end else begin
         state_q      <= state_d;
         sel_stable_q <= sel_stable_d;
         sel_onehot_q <= sel_onehot_d;
         sel_row_q    <= sel_row_d;
         sel_col_q    <= sel_col_d;
         sel_error_q  <= sel_error_d;
         move_valid_q <= move_valid_d;
         move_row_q   <= move_row_d;
         move_col_q   <= move_col_d;
         snap_q       <= snap_d;
      end
   end

   assign move_valid = move_valid_q;
   assign move_row   = move_row_q;
   assign move_col   = move_col_q;
   assign sel_stable = sel_stable_q;
   assign sel_onehot = sel_onehot_q;
   assign sel_row    = sel_row_q;
   assign sel_col    = sel_col_q;
   assign sel_error  = sel_error_q;

endmodule

// File: tb/tb_move_select_decoder.sv
// Randomized bench for move_select_decoder against a transaction-level model of
// the selection, error flag and duplicate-move blocking.
module tb_move_select_decoder;

   localparam int STABLE_CYCLES = 4;
   localparam int CNT_W         = 3;
   localparam int SETTLE        = 12;

   logic       clk, Reset, submit, move_ready;
   logic [7:0] row_sw, col_sw;
   logic       move_valid, sel_stable, sel_onehot, sel_error;
   logic [2:0] move_row, move_col, sel_row, sel_col;

   int checks, failures;

   bit         mdl_error, mdl_wait;
   logic [15:0] mdl_snap;
   logic [7:0] cur_row, cur_col;

   move_select_decoder #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .row_sw     (row_sw),
      .col_sw     (col_sw),
      .submit     (submit),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_row   (move_row),
      .move_col   (move_col),
      .sel_stable (sel_stable),
      .sel_onehot (sel_onehot),
      .sel_row    (sel_row),
      .sel_col    (sel_col),
      .sel_error  (sel_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit bank_ok(input logic [7:0] v);
      return $countones(v) == 1;
   endfunction

   function automatic logic [2:0] bank_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v == (8'd1 << i)) return 3'(i);
      return 3'd0;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] c);
      @(negedge clk);
      row_sw = r;
      col_sw = c;
   endtask

   task automatic doTransaction(input logic [7:0] r, input logic [7:0] c, input bit do_submit,
                                input bit early_submit, input bit early_ready, input bit wiggle,
                                input bit reset_mid, input int bp);
      bit changed;
      bit legal;
      changed = ({r, c} != {cur_row, cur_col});
      legal   = bank_ok(r) && bank_ok(c);
      applyStimulus(r, c);
      cur_row = r;
      cur_col = c;
      repeat (4) @(negedge clk);
      if (changed) begin
         checkOutput("stable_drop", sel_stable, 1'b0);
         if (early_submit) begin
            submit = 1'b1;
            @(negedge clk);
            submit = 1'b0;
            if (!mdl_wait) mdl_error = 1'b1;
            checkOutput("unstable_sub_valid", move_valid, 1'b0);
            checkOutput("unstable_sub_err", sel_error, mdl_error);
         end
      end
      repeat (SETTLE) @(negedge clk);
      checkOutput("sel_stable", sel_stable, 1'b1);
      checkOutput("sel_onehot", sel_onehot, legal);
      checkOutput("sel_row", sel_row, bank_idx(r));
      checkOutput("sel_col", sel_col, bank_idx(c));
      if (mdl_wait && ({r, c} != mdl_snap)) mdl_wait = 1'b0;
      if (!do_submit) return;

      move_ready = early_ready;
      submit     = 1'b1;
      @(negedge clk);
      submit = 1'b0;
      if (mdl_wait || !legal) begin
         if (!mdl_wait) mdl_error = 1'b1;
         move_ready = 1'b0;
         checkOutput("rejected_valid", move_valid, 1'b0);
         checkOutput("rejected_err", sel_error, mdl_error);
         return;
      end
      mdl_error = 1'b0;
      checkOutput("issue_valid", move_valid, 1'b1);
      checkOutput("issue_row", move_row, bank_idx(r));
      checkOutput("issue_col", move_col, bank_idx(c));
      checkOutput("issue_err", sel_error, 1'b0);

      if (early_ready) begin
         @(negedge clk);
         move_ready = 1'b0;
         checkOutput("early_ready_hs", move_valid, 1'b0);
      end else if (reset_mid) begin
         #2 Reset = 1'b1;
         #1;
         checkOutput("async_rst_valid", move_valid, 1'b0);
         checkOutput("async_rst_row", move_row, 3'd0);
         checkOutput("async_rst_col", move_col, 3'd0);
         checkOutput("async_rst_stable", sel_stable, 1'b0);
         checkOutput("async_rst_err", sel_error, 1'b0);
         @(negedge clk);
         Reset     = 1'b0;
         mdl_error = 1'b0;
         mdl_wait  = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("requalify_stable", sel_stable, 1'b0);
            checkOutput("requalify_valid", move_valid, 1'b0);
         end
         return;
      end else begin
         for (int i = 0; i < bp; i++) begin
            if (wiggle) {row_sw, col_sw} = {row_sw, col_sw} ^ 16'($urandom_range(1, 65535));
            submit = 1'($urandom_range(0, 1));
            @(negedge clk);
            submit = 1'b0;
            checkOutput("bp_valid", move_valid, 1'b1);
            checkOutput("bp_row", move_row, bank_idx(r));
            checkOutput("bp_col", move_col, bank_idx(c));
            checkOutput("bp_err", sel_error, 1'b0);
         end
         row_sw     = r;
         col_sw     = c;
         move_ready = 1'b1;
         @(negedge clk);
         move_ready = 1'b0;
         checkOutput("handshake_drop", move_valid, 1'b0);
         @(negedge clk);
         checkOutput("single_handshake", move_valid, 1'b0);
      end
      mdl_wait = 1'b1;
      mdl_snap = {r, c};
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] r, c;
      int kind;
      checks     = 0;
      failures   = 0;
      mdl_error  = 1'b0;
      mdl_wait   = 1'b0;
      mdl_snap   = '0;
      cur_row    = '0;
      cur_col    = '0;
      Reset      = 1'b1;
      submit     = 1'b0;
      move_ready = 1'b0;
      row_sw     = '0;
      col_sw     = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_valid", move_valid, 1'b0);
      checkOutput("reset_stable", sel_stable, 1'b0);
      checkOutput("reset_onehot", sel_onehot, 1'b0);
      checkOutput("reset_err", sel_error, 1'b0);
      checkOutput("reset_move", {move_row, move_col}, 6'd0);
      Reset = 1'b0;

      doTransaction(8'h04, 8'h10, 1, 0, 0, 0, 0, 0);
      doTransaction(8'h06, 8'h01, 1, 0, 0, 0, 0, 0);
      doTransaction(8'h08, 8'h01, 1, 0, 0, 0, 0, 0);
      doTransaction(8'h08, 8'h02, 0, 0, 0, 0, 0, 0);
      doTransaction(8'h08, 8'h80, 1, 1, 0, 0, 0, 0);
      doTransaction(8'h10, 8'h20, 1, 0, 0, 1, 0, 10);
      doTransaction(8'h10, 8'h20, 1, 0, 0, 0, 0, 0);
      doTransaction(8'h40, 8'h20, 1, 0, 1, 0, 0, 0);
      doTransaction(8'h02, 8'h04, 1, 0, 0, 0, 1, 0);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            r = 8'd1 << $urandom_range(0, 7);
            c = 8'd1 << $urandom_range(0, 7);
         end else if (kind <= 7) begin
            r = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
         end else begin
            r = cur_row;
            c = cur_col;
         end
         doTransaction(r, c, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 8));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
